// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NREQ valid/ready requesters
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_ctrl,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_zero,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0]    state;
  logic [PW-1:0] rr_ptr, owner, win;
  logic          found, legal;
  logic [W-1:0]  a_q, b_q, res_q;
  logic [3:0]    ctrl_q;
  logic          zero_q, err_q;
  // first valid requester scanning upward from rr_ptr, wrapping at NREQ
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        win = PW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end
  assign legal      = ctrl_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  assign req_ready  = (state == IDLE && found) ? NREQ'(1) << win : '0;
  assign rsp_valid  = (state == RESP) ? NREQ'(1) << owner : '0;
  assign busy       = state != IDLE;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          a_q    <= req_a[win*W +: W];
          b_q    <= req_b[win*W +: W];
          ctrl_q <= req_ctrl[win*4 +: 4];
          owner  <= win;
          state  <= EXEC;
        end
        EXEC: begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          err_q  <= !legal;
          state  <= RESP;
        end
        RESP: if (rsp_ready[owner]) begin
          rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vector table plus round-robin, backpressure and reset sequences
module tb_alu_share_arbiter;
  localparam int N = 4;
  logic          clk = 1'b0, rst_n;
  logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [N*4-1:0]  req_ctrl;
  logic [31:0]   rsp_result, alu_a, alu_b, alu_result;
  logic          rsp_zero, rsp_err, alu_zero, busy;
  logic [3:0]    alu_ctrl;
  int tests = 0, fails = 0;

  alu_share_arbiter #(.NREQ(N), .W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference ALU attached to the shared port
  always_comb begin
    alu_result = alu_ctrl == 4'b0000 ? alu_a & alu_b :
                 alu_ctrl == 4'b0001 ? alu_a | alu_b :
                 alu_ctrl == 4'b0010 ? alu_a + alu_b :
                 alu_ctrl == 4'b0110 ? alu_a - alu_b :
                 alu_ctrl == 4'b0111 ? {31'd0, alu_a < alu_b} :
                 alu_ctrl == 4'b1100 ? ~alu_a : 32'd0;
    alu_zero = alu_result == 32'd0;
  end

  typedef struct {
    int          idx;
    logic [31:0] a, b;
    logic [3:0]  c;
    logic [31:0] r;
    logic        z, e;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_grant(input string nm, output int n);
    n = 0;
    while (req_ready == '0 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 10) chk({nm, " grant timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input vec_t t, input string nm);
    int n;
    @(negedge clk);
    req_valid = '0;
    req_valid[t.idx] = 1'b1;
    req_a[t.idx*32 +: 32] = t.a;
    req_b[t.idx*32 +: 32] = t.b;
    req_ctrl[t.idx*4 +: 4] = t.c;
    rsp_ready = '1;
    #1;
    wait_grant(nm, n);
    chk({nm, " grant"}, 32'(req_ready), 32'(1 << t.idx));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk({nm, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, " exec alu_a"}, alu_a, t.a);
    chk({nm, " exec alu_ctrl"}, 32'(alu_ctrl), 32'(t.c));
    @(negedge clk);
    chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(1 << t.idx));
    chk({nm, " result"}, rsp_result, t.r);
    chk({nm, " zero/err"}, {30'd0, rsp_zero, rsp_err}, {30'd0, t.z, t.e});
    @(negedge clk);
    chk({nm, " idle"}, 32'(busy), 32'd0);
    chk({nm, " held result"}, rsp_result, t.r);
  endtask

  initial begin
    int n;
    v[0]  = '{0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0};
    v[1]  = '{2, 32'h1234, 32'h1234, 4'b0110, 32'd0, 1'b1, 1'b0};
    v[2]  = '{2, 32'd3, 32'd9, 4'b0111, 32'd1, 1'b0, 1'b0};
    v[3]  = '{1, 32'hFFFFFFFF, 32'd0, 4'b1111, 32'd0, 1'b1, 1'b1};
    v[4]  = '{3, 32'd0, 32'd0, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0};
    v[5]  = '{0, 32'hF0F0, 32'h0FF0, 4'b0000, 32'h00F0, 1'b0, 1'b0};
    v[6]  = '{1, 32'hF000, 32'h000F, 4'b0001, 32'hF00F, 1'b0, 1'b0};
    v[7]  = '{3, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 1'b0};
    v[8]  = '{0, 32'd5, 32'd3, 4'b0110, 32'd2, 1'b0, 1'b0};
    v[9]  = '{1, 32'd9, 32'd3, 4'b0111, 32'd0, 1'b1, 1'b0};
    v[10] = '{2, 32'd1, 32'd2, 4'b0011, 32'd0, 1'b1, 1'b1};
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_ctrl = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {req_ready, rsp_valid, 3'd0, busy, alu_ctrl}, 32'd0);
    chk("reset result", rsp_result, 32'd0);
    rst_n = 1'b1;

    foreach (v[i]) do_op(v[i], $sformatf("vec%0d", i));

    // round robin with every requester asserting continuously
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = 32'(i);
      req_b[i*32 +: 32] = 32'd10;
      req_ctrl[i*4 +: 4] = 4'b0010;
    end
    req_valid = '1;
    rsp_ready = '1;
    #1;
    for (int g = 0; g < 8; g++) begin
      wait_grant("rr", n);
      if (g > 0) chk("rr gap", 32'(n), 32'd0);
      chk("rr grant", 32'(req_ready), 32'(1 << (g % N)));
      @(negedge clk);
      @(negedge clk);
      chk("rr rsp_valid", 32'(rsp_valid), 32'(1 << (g % N)));
      chk("rr handshake cycle ready", 32'(req_ready), 32'd0);
      chk("rr result", rsp_result, 32'(g % N + 10));
      if (g == 7) req_valid = '0;
      @(negedge clk); #1;
    end

    // backpressure on requester 1 while others keep asking
    req_a[32 +: 32] = 32'd20; req_b[32 +: 32] = 32'd22;
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    #1;
    wait_grant("bp", n);
    chk("bp grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b1101;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp rsp_valid", 32'(rsp_valid), 32'b0010);
      chk("bp result", rsp_result, 32'd42);
      chk("bp no ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = '1;
    @(negedge clk); #1;
    chk("bp next grant", 32'(req_ready), 32'b0100);
    req_valid = '0;
    n = 0;
    while (busy !== 1'b0 || n == 0) begin
      @(negedge clk);
      n++;
      if (n > 10) begin
        chk("bp drain timeout", 32'd0, 32'd1);
        break;
      end
    end

    // reset in the middle of EXEC
    req_ctrl[3*4 +: 4] = 4'b0010;
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("mid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset outputs", {req_ready, rsp_valid, 3'd0, busy, alu_ctrl}, 32'd0);
    @(negedge clk);
    chk("mid reset held", {req_ready, rsp_valid, 3'd0, busy, alu_ctrl}, 32'd0);
    chk("mid reset alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk("rr_ptr cleared", 32'(req_ready), 32'b0010);
    req_valid = '0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
